// File: rtl/player_motion_ctrl.sv
// Player sprite controller: accelerating/decaying horizontal motion with clamped bounds,
// frame-rate fire request with cooldown, and a rectangular hit-box pixel test.
module player_motion_ctrl #(
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned X_CENTER      = 320,
  parameter int unsigned Y_POS         = 450,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 639,
  parameter int unsigned HALF_W        = 8,
  parameter int unsigned HALF_H        = 4,
  parameter int unsigned ACCEL         = 1,
  parameter int unsigned MAX_SPEED     = 6,
  parameter int unsigned FIRE_COOLDOWN = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               left,
  input  logic               right,
  input  logic               fire,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [COORD_W-1:0] player_x_pos,
  output logic [COORD_W-1:0] player_y_pos,
  output logic [COORD_W-1:0] player_x_vel,
  output logic               shot_req,
  output logic [COORD_W-1:0] shot_x,
  output logic               cooldown_active,
  output logic               is_player
);

  // Signed arithmetic width: unsigned position plus sign plus one guard bit.
  localparam int unsigned SW   = COORD_W + 2;
  localparam int unsigned EW   = COORD_W + 1;
  localparam int unsigned CD_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] V_STEP = SW'(ACCEL);
  localparam logic signed [SW-1:0] V_MAX  = SW'(MAX_SPEED);
  localparam logic signed [SW-1:0] X_LO   = SW'(X_MIN + HALF_W);
  localparam logic signed [SW-1:0] X_HI   = SW'(X_MAX - HALF_W);

  logic               fc_q;
  logic               tick_q;
  logic [COORD_W-1:0] pos_q, pos_d;
  logic [COORD_W-1:0] vel_q, vel_d;
  logic [COORD_W-1:0] shot_x_q, shot_x_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               shot_q, shot_d;
  logic               cd_act_q, cd_act_d;

  logic signed [SW-1:0] v_cur;
  logic signed [SW-1:0] v_new;
  logic signed [SW-1:0] p_new;

  // Per-frame motion, clamp, fire and cooldown update.
  always_comb begin
    pos_d    = pos_q;
    vel_d    = vel_q;
    shot_x_d = shot_x_q;
    cd_d     = cd_q;
    shot_d   = 1'b0;
    cd_act_d = cd_act_q;

    v_cur = SW'($signed(vel_q));
    v_new = v_cur;
    if (left && !right) begin
      v_new = v_cur - V_STEP;
      if (v_new < -V_MAX) v_new = -V_MAX;
    end else if (right && !left) begin
      v_new = v_cur + V_STEP;
      if (v_new > V_MAX) v_new = V_MAX;
    end else if (v_cur > ZERO) begin
      v_new = (v_cur < V_STEP) ? ZERO : v_cur - V_STEP;
    end else if (v_cur < ZERO) begin
      v_new = (-v_cur < V_STEP) ? ZERO : v_cur + V_STEP;
    end

    p_new = $signed({2'b00, pos_q}) + v_new;
    if (p_new < X_LO) begin
      p_new = X_LO;
      v_new = ZERO;
    end else if (p_new > X_HI) begin
      p_new = X_HI;
      v_new = ZERO;
    end

    if (tick_q) begin
      pos_d = COORD_W'(p_new);
      vel_d = COORD_W'(v_new);
      // Cooldown gate uses the pre-tick count; shot position is the post-move one.
      if (fire && (cd_q == '0)) begin
        shot_d   = 1'b1;
        shot_x_d = COORD_W'(p_new);
        cd_d     = CD_W'(FIRE_COOLDOWN);
      end else if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end
      cd_act_d = (cd_d != '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q     <= 1'b0;
      tick_q   <= 1'b0;
      pos_q    <= COORD_W'(X_CENTER);
      vel_q    <= '0;
      shot_x_q <= '0;
      cd_q     <= '0;
      shot_q   <= 1'b0;
      cd_act_q <= 1'b0;
    end else begin
      fc_q     <= frame_clk;
      tick_q   <= frame_clk & ~fc_q;
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      shot_x_q <= shot_x_d;
      cd_q     <= cd_d;
      shot_q   <= shot_d;
      cd_act_q <= cd_act_d;
    end
  end

  assign player_x_pos    = pos_q;
  assign player_y_pos    = COORD_W'(Y_POS);
  assign player_x_vel    = vel_q;
  assign shot_req        = shot_q;
  assign shot_x          = shot_x_q;
  assign cooldown_active = cd_act_q;

  // Hit-box test widened by one bit so edge-of-screen sums cannot wrap.
  assign is_player = (EW'(DrawX) + EW'(HALF_W) >= EW'(pos_q)) &&
                     (EW'(DrawX) <= EW'(pos_q) + EW'(HALF_W)) &&
                     (EW'(DrawY) + EW'(HALF_H) >= EW'(Y_POS)) &&
                     (EW'(DrawY) <= EW'(Y_POS) + EW'(HALF_H));

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: motion, decay, clamping, fire cadence, tick and reset edges.
module tb_player_motion_ctrl;

  localparam int unsigned W = 10;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         frame_clk = 1'b0;
  logic         left = 1'b0;
  logic         right = 1'b0;
  logic         fire = 1'b0;
  logic [W-1:0] DrawX = '0;
  logic [W-1:0] DrawY = '0;
  logic [W-1:0] player_x_pos;
  logic [W-1:0] player_y_pos;
  logic [W-1:0] player_x_vel;
  logic         shot_req;
  logic [W-1:0] shot_x;
  logic         cooldown_active;
  logic         is_player;

  int n_vec = 0;
  int n_err = 0;
  logic cnt_clr = 1'b1;
  int shot_cnt;

  player_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .left(left), .right(right), .fire(fire),
    .DrawX(DrawX), .DrawY(DrawY),
    .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
    .player_x_vel(player_x_vel), .shot_req(shot_req), .shot_x(shot_x),
    .cooldown_active(cooldown_active), .is_player(is_player)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (cnt_clr) shot_cnt <= 0;
    else if (shot_req) shot_cnt <= shot_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; left = 1'b0; right = 1'b0; fire = 1'b0; frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One frame: low gap, rising edge, then return at the negedge after the update edge.
  task automatic frame(input logic l, input logic r, input logic f);
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk); left = l; right = r; fire = f; frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  function automatic int fire_x(input int k);
    if (k <= 6) return 320 + (k * (k + 1)) / 2;
    return 341 + 6 * (k - 6);
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge Clk);
    n_vec++; if (player_x_pos !== W'(320)) begin n_err++; $display("FAIL reset_x got %0d want 320", player_x_pos); end
    n_vec++; if (player_y_pos !== W'(450)) begin n_err++; $display("FAIL reset_y got %0d want 450", player_y_pos); end
    n_vec++; if (player_x_vel !== W'(0)) begin n_err++; $display("FAIL reset_vel got %0d want 0", player_x_vel); end
    n_vec++; if (shot_req !== 1'b0 || shot_x !== W'(0)) begin n_err++; $display("FAIL reset_shot got %b/%0d want 0/0", shot_req, shot_x); end
    n_vec++; if (cooldown_active !== 1'b0) begin n_err++; $display("FAIL reset_cd got %b want 0", cooldown_active); end
  endtask

  task automatic test_idle_hitbox();
    int px[4] = '{312, 328, 311, 320};
    int py[4] = '{446, 454, 450, 455};
    logic ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (player_x_pos !== W'(320) || player_x_vel !== W'(0) || shot_req !== 1'b0) begin
        n_err++; $display("FAIL idle[%0d] got x=%0d v=%0d s=%b want 320/0/0", i, player_x_pos, player_x_vel, shot_req);
      end
    end
    for (int i = 0; i < 4; i++) begin
      DrawX = W'(px[i]); DrawY = W'(py[i]);
      #1;
      n_vec++; if (is_player !== ex[i]) begin n_err++; $display("FAIL hitbox(%0d,%0d) got %b want %b", px[i], py[i], is_player, ex[i]); end
    end
  endtask

  task automatic test_accel_decay();
    int ev[7] = '{1, 2, 3, 4, 5, 6, 6};
    int ex[7] = '{321, 323, 326, 330, 335, 341, 347};
    int dv[7] = '{5, 4, 3, 2, 1, 0, 0};
    int dx[7] = '{352, 356, 359, 361, 362, 362, 362};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      frame(1'b0, 1'b1, 1'b0);
      n_vec++;
      if (player_x_vel !== W'(ev[i]) || player_x_pos !== W'(ex[i])) begin
        n_err++; $display("FAIL accel[%0d] got v=%0d x=%0d want %0d/%0d", i, player_x_vel, player_x_pos, ev[i], ex[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (player_x_vel !== W'(dv[i]) || player_x_pos !== W'(dx[i])) begin
        n_err++; $display("FAIL decay[%0d] got v=%0d x=%0d want %0d/%0d", i, player_x_vel, player_x_pos, dv[i], dx[i]);
      end
    end
  endtask

  task automatic test_both_decay();
    int bv[5] = '{3, 2, 1, 0, 0};
    int bx[5] = '{333, 335, 336, 336, 336};
    do_reset();
    repeat (4) frame(1'b0, 1'b1, 1'b0);
    n_vec++; if (player_x_vel !== W'(4) || player_x_pos !== W'(330)) begin n_err++; $display("FAIL both_pre got v=%0d x=%0d want 4/330", player_x_vel, player_x_pos); end
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 1'b1, 1'b0);
      n_vec++;
      if (player_x_vel !== W'(bv[i]) || player_x_pos !== W'(bx[i])) begin
        n_err++; $display("FAIL both[%0d] got v=%0d x=%0d want %0d/%0d", i, player_x_vel, player_x_pos, bv[i], bx[i]);
      end
    end
  endtask

  // Starts from x=362 vel=0 (end of accel/decay); right clamps on frame 48, left on frame 107.
  task automatic test_boundary();
    repeat (4) frame(1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (7) frame(1'b0, 1'b1, 1'b0);
    repeat (7) frame(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      frame(1'b0, 1'b1, 1'b0);
      if (player_x_pos < W'(8) || player_x_pos > W'(631)) begin
        n_vec++; n_err++; $display("FAIL right_range[%0d] got %0d want 8..631", k, player_x_pos);
      end
      if (k == 47) begin
        n_vec++; if (player_x_pos !== W'(629) || player_x_vel !== W'(6)) begin n_err++; $display("FAIL right_pre got x=%0d v=%0d want 629/6", player_x_pos, player_x_vel); end
      end
      if (k == 48) begin
        n_vec++; if (player_x_pos !== W'(631) || player_x_vel !== W'(0)) begin n_err++; $display("FAIL right_clamp got x=%0d v=%0d want 631/0", player_x_pos, player_x_vel); end
      end
    end
    n_vec++; if (player_x_pos !== W'(631) || player_x_vel !== W'(0)) begin n_err++; $display("FAIL right_hold got x=%0d v=%0d want 631/0", player_x_pos, player_x_vel); end
    for (int k = 1; k <= 110; k++) begin
      frame(1'b1, 1'b0, 1'b0);
      if (player_x_pos < W'(8) || player_x_pos > W'(631)) begin
        n_vec++; n_err++; $display("FAIL left_range[%0d] got %0d want 8..631", k, player_x_pos);
      end
      if (k == 106) begin
        n_vec++; if (player_x_pos !== W'(10) || player_x_vel !== W'(-6)) begin n_err++; $display("FAIL left_pre got x=%0d v=%0d want 10/-6", player_x_pos, $signed(player_x_vel)); end
      end
      if (k == 107) begin
        n_vec++; if (player_x_pos !== W'(8) || player_x_vel !== W'(0)) begin n_err++; $display("FAIL left_clamp got x=%0d v=%0d want 8/0", player_x_pos, $signed(player_x_vel)); end
      end
    end
    n_vec++; if (player_x_pos !== W'(8) || player_x_vel !== W'(0)) begin n_err++; $display("FAIL left_hold got x=%0d v=%0d want 8/0", player_x_pos, $signed(player_x_vel)); end
  endtask

  task automatic test_fire();
    logic exp_shot;
    logic exp_cd;
    do_reset();
    @(negedge Clk); cnt_clr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      frame(1'b0, 1'b1, 1'b1);
      exp_shot = (((k - 1) % 16) == 0);
      exp_cd   = (((k - 1) % 16) < 15);
      n_vec++; if (shot_req !== exp_shot) begin n_err++; $display("FAIL fire_shot[%0d] got %b want %b", k, shot_req, exp_shot); end
      n_vec++; if (cooldown_active !== exp_cd) begin n_err++; $display("FAIL fire_cd[%0d] got %b want %b", k, cooldown_active, exp_cd); end
      if (exp_shot) begin
        n_vec++; if (shot_x !== W'(fire_x(k)) || player_x_pos !== W'(fire_x(k))) begin
          n_err++; $display("FAIL fire_x[%0d] got shot_x=%0d x=%0d want %0d", k, shot_x, player_x_pos, fire_x(k));
        end
      end
    end
    @(negedge Clk);
    @(negedge Clk);
    n_vec++; if (shot_cnt !== 3) begin n_err++; $display("FAIL fire_pulses got %0d want 3", shot_cnt); end
    n_vec++; if (shot_x !== W'(fire_x(33))) begin n_err++; $display("FAIL fire_hold got %0d want %0d", shot_x, fire_x(33)); end
    cnt_clr = 1'b1;
  endtask

  task automatic test_held_frame();
    do_reset();
    @(negedge Clk); right = 1'b1; frame_clk = 1'b1;
    repeat (50) @(negedge Clk);
    n_vec++; if (player_x_vel !== W'(1) || player_x_pos !== W'(321)) begin n_err++; $display("FAIL held_frame got v=%0d x=%0d want 1/321", player_x_vel, player_x_pos); end
    frame_clk = 1'b0; right = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame(1'b0, 1'b0, 1'b1);
    repeat (2) frame(1'b0, 1'b0, 1'b0);
    repeat (4) frame(1'b0, 1'b1, 1'b0);
    n_vec++; if (player_x_vel !== W'(4) || cooldown_active !== 1'b1) begin n_err++; $display("FAIL mid_pre got v=%0d cd=%b want 4/1", player_x_vel, cooldown_active); end
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk); frame_clk = 1'b1; right = 1'b1; fire = 1'b1;
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; right = 1'b0; fire = 1'b0;
    @(negedge Clk);
    n_vec++;
    if (player_x_pos !== W'(320) || player_x_vel !== W'(0) || cooldown_active !== 1'b0 || shot_req !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got x=%0d v=%0d cd=%b s=%b want 320/0/0/0", player_x_pos, player_x_vel, cooldown_active, shot_req);
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    n_vec++;
    if (player_x_pos !== W'(320) || player_x_vel !== W'(0) || shot_req !== 1'b0) begin
      n_err++; $display("FAIL mid_after got x=%0d v=%0d s=%b want 320/0/0", player_x_pos, player_x_vel, shot_req);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hitbox();
    test_accel_decay();
    test_both_decay();
    test_boundary();
    test_fire();
    test_held_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Parametrised player sprite controller for the shooter playfield. It replaces fixed-step horizontal motion with an accelerating and decaying velocity model and clamps the player to configurable bounds. It adds a frame-rate fire request with a cooldown and a rectangular hit-box pixel test. It sits between keyboard/button decode and the color mapper / projectile spawner, and updates once per frame_clk rising edge.

Parameters:
COORD_W, 10, width of all coordinate and velocity buses
X_CENTER, 320, reset X position
Y_POS, 450, fixed Y position of the player
X_MIN, 0, leftmost playfield pixel
X_MAX, 639, rightmost playfield pixel
HALF_W, 8, hit-box half-width (pixels)
HALF_H, 4, hit-box half-height (pixels)
ACCEL, 1, velocity change per frame (pixels/frame)
MAX_SPEED, 6, velocity magnitude limit; constraint MAX_SPEED < 2^(COORD_W-2)
FIRE_COOLDOWN, 15, frames loaded into the cooldown counter after a shot

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  vsync-rate frame clock, asynchronous in phase to Clk edges but sampled only on Clk
left  in  1  move-left request
right  in  1  move-right request
fire  in  1  fire request (level)
DrawX  in  COORD_W  current pixel X
DrawY  in  COORD_W  current pixel Y
player_x_pos  out  COORD_W  player centre X
player_y_pos  out  COORD_W  player centre Y (always Y_POS)
player_x_vel  out  COORD_W  signed two's-complement velocity
shot_req  out  1  one-Clk pulse requesting a projectile spawn
shot_x  out  COORD_W  X coordinate of the requested shot
cooldown_active  out  1  high while the cooldown counter is nonzero
is_player  out  1  combinational: current pixel lies inside the hit-box

Behaviour:
- Edge detect: fc_d <= frame_clk; tick <= frame_clk & ~fc_d (registered). All state below updates only on Clk edges where tick=1. One update per frame_clk rise; frame_clk held high produces no further ticks.
- Reset values: player_x_pos=X_CENTER, player_y_pos=Y_POS, vel=0, cooldown=0, shot_req=0, shot_x=0, fc_d=0, tick=0.
- Reset mid-frame: takes effect on that Clk edge, and a pending tick is discarded.
- Velocity update on tick (v = current vel):
  - left & ~right: v' = max(v-ACCEL, -MAX_SPEED).
  - right & ~left: v' = min(v+ACCEL, +MAX_SPEED).
  - both or neither: decay toward 0 by ACCEL without crossing 0; if |v| < ACCEL, then v' = 0.
- Position update, same tick: p' = p + v', computed signed with one guard bit. Clamp to [X_MIN+HALF_W, X_MAX-HALF_W].
  - If clamped, p' = bound and v' = 0.
  - Defaults give a range of 8..631.
- Fire and cooldown on tick, using the pre-tick cooldown value c:
  - fire & c==0: shot_req=1 for exactly the next Clk cycle, shot_x=p' (post-move position), cooldown=FIRE_COOLDOWN.
  - Otherwise: cooldown = c-1 if c>0, else 0. shot_req is 0 on every cycle except that one.
  - Holding fire continuously yields a shot every FIRE_COOLDOWN+1 ticks.
- shot_x holds its value until the next shot.
- cooldown_active = (cooldown != 0), registered.
- Latency: position, velocity and shot outputs are valid the Clk cycle after the tick cycle, i.e. 2 Clk cycles after the Clk edge that first samples frame_clk high.
- is_player: 1 iff DrawX+HALF_W >= x, DrawX <= x+HALF_W, DrawY+HALF_H >= y, and DrawY <= y+HALF_H. Evaluate unsigned at COORD_W+1 bits, so there is no wrap at the screen edges and no multipliers.
- left/right/fire are sampled only on tick cycles; pulses between ticks are ignored.

Test Plan:
- Reset, then 3 ticks with no input -> x=320, y=450, vel=0, shot_req never asserted, is_player=1 at (DrawX,DrawY)=(312,446) and (328,454), 0 at (311,450) and (320,455).
- Hold right from reset for 7 ticks -> vel 1,2,3,4,5,6,6; x 321,323,326,330,335,341,347.
- Release after vel=6 at x=347, 7 ticks idle -> vel 5,4,3,2,1,0,0; x 352,356,359,361,362,362,362. Holding left+right together gives the same decay.
- Hold right until the boundary -> x saturates at exactly 631 with vel=0 on the clamp tick. Then hold left until the boundary -> x saturates at 8 with vel=0. The x bus never shows a value outside 8..631.
- Hold fire from reset for 40 ticks -> shot_req single-Clk pulses at ticks 1, 17, 33 only. shot_x equals x after each of those ticks. cooldown_active is high from tick 1 through tick 15, and correspondingly after each later shot.
- Hold frame_clk high for 50 Clk cycles -> exactly one tick. Assert Reset during a frame with vel=4 and cooldown=9 -> next cycle x=320, vel=0, cooldown_active=0, no shot_req.
